// File: rtl/ifetch_queue_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response
// channel and the decode handshake.
interface ifetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, dec_ready,
        output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, dec_ready,
        input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: credit-limited pipelined fetch into a small
// {pc, instr} FIFO, with redirect flush and stale-response dropping.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic           clk,
    input  logic           reset,
    ifetch_queue_if.master bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [SW-1:0] credits_used;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [CW-1:0] outstanding_next;
    logic [31:0]   redirect_target;

    always_comb begin
        credits_used    = SW'(outstanding) + SW'(count);
        credit_ok       = credits_used < SW'(DEPTH);
        redirect_target = bus.redirect_pc & ~32'h0000_0003;
        req_fire        = bus.imem_req_valid && bus.imem_req_ready;
        // A response landing in a redirect cycle is stale even if drop_cnt is 0.
        rsp_drop        = bus.imem_rsp_valid && (bus.redirect_valid || (drop_cnt != '0));
        push            = bus.imem_rsp_valid && !rsp_drop;
        pop             = bus.dec_valid && bus.dec_ready;

        outstanding_next = outstanding;
        case ({req_fire, bus.imem_rsp_valid})
            2'b10:   outstanding_next = outstanding + CW'(1);
            2'b01:   outstanding_next = outstanding - CW'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    assign bus.imem_req_valid = reset && credit_ok && !bus.redirect_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.dec_valid      = (count != '0);
    assign bus.dec_pc         = bus.dec_valid ? pc_mem[rd_ptr]    : '0;
    assign bus.dec_instr      = bus.dec_valid ? instr_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (bus.redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                drop_cnt <= outstanding_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: memory model, directed fetch/redirect/reset
// scenarios, and a monitor that checks every decode handshake against expectations.
module tb_ifetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    logic clk;
    logic reset;
    ifetch_queue_if bus ();

    ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned pops     = 0;
    int unsigned mem_lat  = 1;
    bit          rand_mode = 0;
    logic [31:0] exp_q [$];
    req_t        pend [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_stream(input logic [31:0] start);
        exp_q.delete();
        for (int unsigned i = 0; i < 512; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_pops(input string name, input int unsigned n, input int unsigned budget);
        int unsigned start;
        int unsigned k;
        start = pops;
        k = 0;
        while (pops < start + n && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        checks++;
        if (pops < start + n) begin
            failures++;
            $display("FAIL %s: pops=%0d required=%0d", name, pops - start, n);
        end
    endtask

    // Instruction memory: in-order responses, latency >= 1, optional random ready.
    initial begin
        int unsigned cyc;
        int unsigned last_due;
        int unsigned lat;
        req_t r;
        cyc = 0;
        last_due = 0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!reset) begin
                pend.delete();
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = 32'hDEAD_BEEF;
                bus.imem_req_ready = 1'b1;
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
                if (pend.size() != 0 && pend[0].due <= cyc) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = instr_of(pend[0].addr);
                    void'(pend.pop_front());
                end
                bus.imem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            if (reset && bus.imem_req_valid && bus.imem_req_ready) begin
                lat = rand_mode ? $urandom_range(1, 5) : mem_lat;
                r.addr = bus.imem_req_addr;
                r.due  = cyc + lat;
                if (r.due <= last_due) r.due = last_due + 1;
                last_due = r.due;
                pend.push_back(r);
            end
        end
    end

    // Monitor: decode handshakes, stall stability, zero-when-idle, credit bound.
    initial begin
        logic        stall_q;
        logic [31:0] stall_pc;
        logic [31:0] stall_instr;
        logic [31:0] e;
        stall_q = 1'b0;
        stall_pc = '0;
        stall_instr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_q = 1'b0;
                chk("rst_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
            end else begin
                checks++;
                if (pend.size() > DEPTH) begin
                    failures++;
                    $display("FAIL credit_limit: in_flight=%0d limit=%0d", pend.size(), DEPTH);
                end
                if (stall_q) begin
                    chk("stall_valid", {31'b0, bus.dec_valid}, 32'd1);
                    chk("stall_pc", bus.dec_pc, stall_pc);
                    chk("stall_instr", bus.dec_instr, stall_instr);
                end
                if (bus.dec_valid && bus.dec_ready) begin
                    if (!bus.redirect_valid) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL dec_unexpected: got pc %h expected none", bus.dec_pc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("dec_pc", bus.dec_pc, e);
                            chk("dec_instr", bus.dec_instr, instr_of(e));
                        end
                        pops++;
                    end
                end else if (!bus.dec_valid) begin
                    chk("idle_pc_zero", bus.dec_pc, 32'd0);
                    chk("idle_instr_zero", bus.dec_instr, 32'd0);
                end
                stall_q     = bus.dec_valid && !bus.dec_ready && !bus.redirect_valid;
                stall_pc    = bus.dec_pc;
                stall_instr = bus.dec_instr;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int unsigned gaps;
        bit found;
        logic [31:0] tgt [4];
        tgt[0] = 32'h0000_1000;
        tgt[1] = 32'h0000_2004;
        tgt[2] = 32'h0000_3FFC;
        tgt[3] = 32'h0000_4010;

        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.dec_ready      = 1'b1;
        exp_stream(RESET_PC);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
        chk("rst_dec_pc", bus.dec_pc, 32'd0);
        chk("rst_dec_instr", bus.dec_instr, 32'd0);

        // Release: request in cycle 0, decode in cycle 2, then back-to-back.
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("c0_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("c0_req_addr", bus.imem_req_addr, 32'h0);
        chk("c0_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
        @(negedge clk);
        chk("c1_req_addr", bus.imem_req_addr, 32'h4);
        chk("c1_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
        @(negedge clk);
        chk("c2_dec_valid", {31'b0, bus.dec_valid}, 32'd1);
        chk("c2_dec_pc", bus.dec_pc, 32'h0);
        gaps = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.dec_valid) gaps++;
        end
        chk("throughput_gaps", gaps, 32'd0);

        // Decode stall: FIFO fills, requests stop, then drains without gaps.
        @(posedge clk); #1 bus.dec_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("stall_in_flight", pend.size(), 32'd0);
        @(posedge clk); #1 bus.dec_ready = 1'b1;
        gaps = 0;
        repeat (6) begin
            @(negedge clk);
            if (!bus.dec_valid) gaps++;
        end
        chk("drain_gaps", gaps, 32'd0);

        // Redirect to 0x100 (low bits ignored).
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        exp_stream(32'h0000_0100);
        @(negedge clk);
        chk("redir1_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir1_req_addr", bus.imem_req_addr, 32'h0000_0100);
        chk("redir1_r1_valid", {31'b0, bus.dec_valid}, 32'd0);
        @(negedge clk);
        chk("redir1_r2_valid", {31'b0, bus.dec_valid}, 32'd0);
        @(negedge clk);
        chk("redir1_r3_valid", {31'b0, bus.dec_valid}, 32'd1);
        chk("redir1_r3_pc", bus.dec_pc, 32'h0000_0100);

        // Redirect coinciding with a response and a decode pop, several in flight.
        mem_lat = 3;
        repeat (8) @(posedge clk);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(posedge clk); #3;
            if (bus.imem_rsp_valid && bus.dec_valid) found = 1;
        end
        chk("redir2_setup", {31'b0, found}, 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        exp_stream(32'h0000_0200);
        @(negedge clk);
        chk("redir2_pop_valid", {31'b0, bus.dec_valid}, 32'd1);
        chk("redir2_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir2_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("redir2_req_addr", bus.imem_req_addr, 32'h0000_0200);
        wait_pops("redir2_new_stream", 4, 40);

        // Back-to-back redirects: the last one wins.
        mem_lat = 2;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0300;
        exp_stream(32'h0000_0300);
        @(posedge clk); #1;
        bus.redirect_pc    = 32'h0000_0400;
        exp_stream(32'h0000_0400);
        @(negedge clk);
        chk("redir3_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir3_req_addr", bus.imem_req_addr, 32'h0000_0400);
        wait_pops("redir3_new_stream", 4, 40);

        // PC wrap-around.
        mem_lat = 1;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        exp_stream(32'hFFFF_FFFC);
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        wait_pops("wrap_stream", 3, 30);

        // Random latency, ready and decode back-pressure with periodic redirects.
        rand_mode = 1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 80; c++) begin
                @(posedge clk); #1;
                bus.dec_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = tgt[r];
            exp_stream(tgt[r]);
            @(posedge clk); #1 bus.redirect_valid = 1'b0;
        end
        rand_mode = 0;
        bus.dec_ready = 1'b1;
        wait_pops("rand_tail", 3, 80);

        // Reset with requests in flight.
        mem_lat = 4;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0800;
        exp_stream(32'h0000_0800);
        @(posedge clk); #1 bus.redirect_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #3;
            if (pend.size() >= 3) found = 1;
        end
        chk("mrst_setup", {31'b0, found}, 32'd1);
        reset = 1'b0;
        exp_stream(RESET_PC);
        #1;
        chk("mrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("mrst_req_addr", bus.imem_req_addr, RESET_PC);
        chk("mrst_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
        chk("mrst_dec_pc", bus.dec_pc, 32'd0);
        chk("mrst_dec_instr", bus.dec_instr, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mrst_restart_addr", bus.imem_req_addr, RESET_PC);
        wait_pops("mrst_restart_stream", 4, 40);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
